// File: rtl/line_beat_shifter_pkg.sv
// Shared definitions for the line beat shifter and its beat counter.
package line_beat_shifter_pkg;

    // Shifter state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Counter width: clog2 of the beat count, never narrower than one bit
    function automatic int calc_cnt_w(input int beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/line_beat_shifter_beat_counter.sv
// Modulo-BEATS beat counter with clear, increment and a last-beat flag.
module beat_counter
    import line_beat_shifter_pkg::*;
#(
    parameter int BEATS = 2,
    parameter int CNT_W = calc_cnt_w(BEATS)
) (
    input  logic             clk,
    input  logic             not_reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Last beat flag: the increment on this value wraps the count to zero
    assign last = (cnt_q == CNT_W'(BEATS - 1));
    assign cnt  = cnt_q;

    // Next count: clear wins, increment wraps at BEATS-1
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc)
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end

    // Count register
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/line_beat_shifter.sv
// Cache line assembly/disassembly register: serial fill from the memory
// bus, parallel load from the data array, serial drain back to memory.
module line_beat_shifter
    import line_beat_shifter_pkg::*;
#(
    parameter int LINE_WIDTH = 64,
    parameter int BEAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  not_reset,
    input  logic                  par_load,
    input  logic [LINE_WIDTH-1:0] par_din,
    input  logic                  start_fill,
    input  logic                  start_drain,
    input  logic                  abort,
    input  logic                  fill_valid,
    output logic                  fill_ready,
    input  logic [BEAT_WIDTH-1:0] fill_data,
    output logic                  drain_valid,
    input  logic                  drain_ready,
    output logic [BEAT_WIDTH-1:0] drain_data,
    output logic [LINE_WIDTH-1:0] dout,
    output logic                  busy,
    output logic                  line_done
);

    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = calc_cnt_w(BEATS);

    logic [1:0]            state_q, state_d;
    logic [LINE_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  cnt_inc, cnt_clr, cnt_last;
    logic [LINE_WIDTH-1:0] fill_shift;
    // Beat index is exported by the counter for burst addressing in the
    // controller; the shifter itself only needs the last flag.
    logic [CNT_W-1:0]      beat_idx_unused;

    // New beat enters at the MSBs so the first beat ends up in the LSBs
    if (BEATS == 1) begin : g_one_beat
        assign fill_shift = fill_data;
    end else begin : g_multi_beat
        assign fill_shift = {fill_data, data_q[LINE_WIDTH-1:BEAT_WIDTH]};
    end

    assign fill_ready  = (state_q == ST_FILL);
    assign drain_valid = (state_q == ST_DRAIN);
    assign busy        = (state_q != ST_IDLE);
    assign drain_data  = data_q[BEAT_WIDTH-1:0];
    assign dout        = data_q;
    assign line_done   = done_q;

    beat_counter #(
        .BEATS (BEATS),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk       (clk),
        .not_reset (not_reset),
        .inc       (cnt_inc),
        .clr       (cnt_clr),
        .cnt       (beat_idx_unused),
        .last      (cnt_last)
    );

    // Command decode and beat transfer; abort beats a same-cycle handshake
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        done_d  = 1'b0;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (par_load) begin
                    data_d = par_din;
                end else if (start_fill) begin
                    state_d = ST_FILL;
                    cnt_clr = 1'b1;
                end else if (start_drain) begin
                    state_d = ST_DRAIN;
                    cnt_clr = 1'b1;
                end
            end
            ST_FILL: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (fill_valid) begin
                    data_d  = fill_shift;
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end else if (drain_ready) begin
                    data_d  = data_q >> BEAT_WIDTH;
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // State, line data and burst-done registers
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_line_beat_shifter.sv
// Directed bench for line_beat_shifter: a 64/32 instance for fill, drain,
// priority, back-to-back and reset cases, and a 128/32 instance for abort.
module tb_line_beat_shifter;

    logic clk = 1'b0;
    logic not_reset = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 64-bit line, 32-bit beats
    logic        a_par_load = 0, a_start_fill = 0, a_start_drain = 0, a_abort = 0;
    logic        a_fill_valid = 0, a_drain_ready = 0;
    logic [63:0] a_par_din = '0;
    logic [31:0] a_fill_data = '0;
    logic        a_fill_ready, a_drain_valid, a_busy, a_line_done;
    logic [31:0] a_drain_data;
    logic [63:0] a_dout;

    // Instance B: 128-bit line, 32-bit beats
    logic         b_par_load = 0, b_start_fill = 0, b_start_drain = 0, b_abort = 0;
    logic         b_fill_valid = 0, b_drain_ready = 0;
    logic [127:0] b_par_din = '0;
    logic [31:0]  b_fill_data = '0;
    logic         b_fill_ready, b_drain_valid, b_busy, b_line_done;
    logic [31:0]  b_drain_data;
    logic [127:0] b_dout;

    line_beat_shifter #(.LINE_WIDTH(64), .BEAT_WIDTH(32)) u_a (
        .clk(clk), .not_reset(not_reset), .par_load(a_par_load), .par_din(a_par_din),
        .start_fill(a_start_fill), .start_drain(a_start_drain), .abort(a_abort),
        .fill_valid(a_fill_valid), .fill_ready(a_fill_ready), .fill_data(a_fill_data),
        .drain_valid(a_drain_valid), .drain_ready(a_drain_ready), .drain_data(a_drain_data),
        .dout(a_dout), .busy(a_busy), .line_done(a_line_done)
    );

    line_beat_shifter #(.LINE_WIDTH(128), .BEAT_WIDTH(32)) u_b (
        .clk(clk), .not_reset(not_reset), .par_load(b_par_load), .par_din(b_par_din),
        .start_fill(b_start_fill), .start_drain(b_start_drain), .abort(b_abort),
        .fill_valid(b_fill_valid), .fill_ready(b_fill_ready), .fill_data(b_fill_data),
        .drain_valid(b_drain_valid), .drain_ready(b_drain_ready), .drain_data(b_drain_data),
        .dout(b_dout), .busy(b_busy), .line_done(b_line_done)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_drain_q[$];
    logic [63:0] exp_done_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard monitor: pop and compare on each drain handshake / line_done
    always @(negedge clk) begin
        if (not_reset) begin
            if (a_drain_valid && a_drain_ready) begin
                checks++;
                if (exp_drain_q.size() == 0) begin
                    errors++;
                    $display("FAIL drain_beat: unexpected beat %0h", a_drain_data);
                end else begin
                    logic [31:0] e;
                    e = exp_drain_q.pop_front();
                    if (a_drain_data !== e) begin
                        errors++;
                        $display("FAIL drain_beat: got %0h expected %0h", a_drain_data, e);
                    end
                end
            end
            if (a_line_done) begin
                checks++;
                if (exp_done_q.size() == 0) begin
                    errors++;
                    $display("FAIL line_done: unexpected pulse, dout %0h", a_dout);
                end else begin
                    logic [63:0] e;
                    e = exp_done_q.pop_front();
                    if (a_dout !== e) begin
                        errors++;
                        $display("FAIL done_dout: got %0h expected %0h", a_dout, e);
                    end
                end
            end
            if (b_line_done) begin
                checks++;
                errors++;
                $display("FAIL b_line_done: unexpected pulse, dout %0h", b_dout);
            end
        end
    end

    initial begin
        // Reset state
        #12;
        chk("rst_dout", a_dout, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_fill_ready", a_fill_ready, 0);
        chk("rst_drain_valid", a_drain_valid, 0);
        chk("rst_drain_data", a_drain_data, 0);
        chk("rst_line_done", a_line_done, 0);
        @(negedge clk);
        not_reset = 1'b1;

        // Fill two beats, then drain back-to-back from the line_done cycle
        cyc(); a_start_fill = 1;
        smp(); chk("fill_pre_busy", a_busy, 0);
        cyc(); a_start_fill = 0; a_fill_valid = 1; a_fill_data = 32'hAAAA_0001;
        exp_done_q.push_back(64'hBBBB_0002_AAAA_0001);
        smp(); chk("fill_ready", a_fill_ready, 1); chk("fill_busy", a_busy, 1);
        cyc(); a_fill_data = 32'hBBBB_0002;
        smp(); chk("fill_partial", a_dout, 64'hAAAA_0001_0000_0000);
        cyc(); a_fill_valid = 0; a_start_drain = 1;
        exp_drain_q.push_back(32'hAAAA_0001);
        exp_drain_q.push_back(32'hBBBB_0002);
        exp_done_q.push_back(64'h0);
        smp(); chk("fill_done_pulse", a_line_done, 1); chk("fill_done_busy", a_busy, 0);
        cyc(); a_start_drain = 0; a_drain_ready = 1;
        smp(); chk("b2b_drain_valid", a_drain_valid, 1);
        cyc();
        smp();
        cyc(); a_drain_ready = 0;
        smp(); chk("b2b_done_pulse", a_line_done, 1); chk("b2b_busy", a_busy, 0);
        cyc();
        smp(); chk("done_one_cycle", a_line_done, 0);

        // par_load during FILL is ignored; abort leaves data intact
        a_par_load = 1; a_par_din = 64'h1122_3344_5566_7788;
        cyc(); a_par_load = 0; a_start_fill = 1;
        smp(); chk("pl_load", a_dout, 64'h1122_3344_5566_7788);
        cyc(); a_start_fill = 0; a_par_load = 1; a_par_din = '1;
        cyc(); a_par_load = 0; a_abort = 1;
        smp(); chk("pl_ignored", a_dout, 64'h1122_3344_5566_7788); chk("pl_busy", a_busy, 1);
        cyc(); a_abort = 0;
        smp(); chk("abort64_busy", a_busy, 0); chk("abort64_nodone", a_line_done, 0);
        chk("abort64_dout", a_dout, 64'h1122_3344_5566_7788);

        // Priority: par_load beats start_fill in the same IDLE cycle
        cyc(); a_par_load = 1; a_start_fill = 1; a_par_din = 64'h0F0E_0D0C_0B0A_0908;
        cyc(); a_par_load = 0; a_start_fill = 0;
        smp(); chk("prio_dout", a_dout, 64'h0F0E_0D0C_0B0A_0908);
        chk("prio_fill_ready", a_fill_ready, 0); chk("prio_busy", a_busy, 0);
        cyc();
        smp(); chk("prio_still_idle", a_fill_ready, 0);

        // Drain with backpressure
        a_par_load = 1; a_par_din = 64'h1122_3344_5566_7788;
        cyc(); a_par_load = 0; a_start_drain = 1;
        exp_drain_q.push_back(32'h5566_7788);
        exp_drain_q.push_back(32'h1122_3344);
        exp_done_q.push_back(64'h0);
        cyc(); a_start_drain = 0; a_drain_ready = 0;
        smp(); chk("bp_valid", a_drain_valid, 1); chk("bp_hold0", a_drain_data, 32'h5566_7788);
        cyc(); a_drain_ready = 1;
        smp();
        cyc(); a_drain_ready = 0;
        smp(); chk("bp_hold1", a_drain_data, 32'h1122_3344); chk("bp_dout", a_dout, 64'h1122_3344);
        cyc(); a_drain_ready = 1;
        smp();
        cyc(); a_drain_ready = 0;
        smp(); chk("bp_busy", a_busy, 0); chk("bp_dout0", a_dout, 0);

        // Asynchronous reset mid-DRAIN
        cyc(); a_par_load = 1; a_par_din = 64'hDEAD_BEEF_CAFE_F00D;
        cyc(); a_par_load = 0; a_start_drain = 1;
        cyc(); a_start_drain = 0;
        smp(); chk("mr_drain_valid", a_drain_valid, 1);
        #2 not_reset = 1'b0;
        #1;
        chk("mr_dout", a_dout, 0); chk("mr_busy", a_busy, 0); chk("mr_drain_valid0", a_drain_valid, 0);
        cyc();
        smp(); chk("mr_nodone", a_line_done, 0);
        not_reset = 1'b1;

        // Abort on the 128-bit instance together with a third valid beat
        cyc(); b_start_fill = 1;
        cyc(); b_start_fill = 0; b_fill_valid = 1; b_fill_data = 32'h1;
        cyc(); b_fill_data = 32'h2;
        cyc(); b_fill_data = 32'h3; b_abort = 1;
        smp(); chk("b_pre_abort_busy", b_busy, 1);
        chk("b_two_beats", b_dout, 128'h0000_0002_0000_0001_0000_0000_0000_0000);
        cyc(); b_abort = 0; b_fill_valid = 0;
        smp(); chk("b_abort_dout", b_dout, 128'h0000_0002_0000_0001_0000_0000_0000_0000);
        chk("b_abort_busy", b_busy, 0); chk("b_abort_nodone", b_line_done, 0);
        cyc();
        smp(); chk("b_abort_nodone2", b_line_done, 0);

        cyc(); cyc();
        chk("drain_q_empty", exp_drain_q.size(), 0);
        chk("done_q_empty", exp_done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
